// File: rtl/ref_read_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ref_read_responder_pkg
// Brief   : Shared widths and FSM encoding for the burst-read responder.
// Revision: 1.0 - initial release
// ============================================================================
package ref_read_responder_pkg;

    localparam int BEAT_W = 256;
    localparam int ID_W   = 6;
    localparam int LEN_W  = 8;
    // Beat counter must hold rd_len_in+1, i.e. up to 256.
    localparam int CNT_W  = LEN_W + 1;
    localparam int FIFO_W = 1 + ID_W + BEAT_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage : ref_read_responder_pkg
`default_nettype wire

// File: rtl/ref_read_responder_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module  : resp_beat_fifo
// Brief   : Two-entry FIFO carrying {last, id, data} read beats.
// Revision: 1.0 - initial release
// ============================================================================
module resp_beat_fifo
    import ref_read_responder_pkg::*;
#(
    parameter int WIDTH = FIFO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] entry0_q;
    logic [WIDTH-1:0] entry1_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                if (wr_ptr_q) begin
                    entry1_q <= din_i;
                end else begin
                    entry0_q <= din_i;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign dout_o  = rd_ptr_q ? entry1_q : entry0_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule : resp_beat_fifo
`default_nettype wire

// File: rtl/ref_read_responder.sv
`default_nettype none
// ============================================================================
// Module  : ref_read_responder
// Brief   : Burst-read responder streaming 256-bit words from an on-chip store.
// Revision: 1.0 - initial release
// ============================================================================
module ref_read_responder
    import ref_read_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   rd_id_in,
    input  logic [32:0]       rd_addr_in,
    input  logic [LEN_W-1:0]  rd_len_in,
    input  logic              rd_info_valid_in,
    output logic              rd_info_rdy_out,
    output logic [BEAT_W-1:0] rd_data_out,
    output logic [ID_W-1:0]   rd_data_id_out,
    output logic              rd_data_last_out,
    output logic              rd_data_valid_out,
    input  logic              rd_data_rdy_in,
    input  logic              wr_en_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [BEAT_W-1:0] wr_data_in
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   idx_d;
    logic [CNT_W-1:0]    remain_q;
    logic [CNT_W-1:0]    remain_d;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     id_d;
    logic                info_rdy_q;

    logic                issue;
    logic                issue_last;
    logic                credit;
    logic [2:0]          occupancy;

    logic                inflight_q;
    logic                inflight_last_q;
    logic [ID_W-1:0]     inflight_id_q;
    logic [BEAT_W-1:0]   rdata_q;
    logic [BEAT_W-1:0]   store_q [DEPTH];

    logic                fifo_valid;
    logic                fifo_pop;
    logic [1:0]          fifo_count;
    logic [FIFO_W-1:0]   fifo_dout;

    logic                w_unused_addr;
    assign w_unused_addr = ^{rd_addr_in[32:ADDR_W+5], rd_addr_in[4:0]};

    // Reserve a FIFO slot for every read still in the store pipeline so the
    // FIFO can absorb all of them regardless of consumer backpressure.
    assign fifo_pop  = fifo_valid & rd_data_rdy_in;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    assign credit    = (occupancy < 3'd2);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        remain_d   = remain_q;
        id_d       = id_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_info_valid_in && info_rdy_q) begin
                    id_d     = rd_id_in;
                    idx_d    = rd_addr_in[ADDR_W+4:5];
                    remain_d = {1'b0, rd_len_in} + CNT_W'(1);
                    state_d  = ST_BURST;
                end
            end
            ST_BURST: begin
                if (credit) begin
                    issue      = 1'b1;
                    issue_last = (remain_q == CNT_W'(1));
                    idx_d      = idx_q + ADDR_W'(1);
                    remain_d   = remain_q - CNT_W'(1);
                    if (issue_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            remain_q   <= '0;
            id_q       <= '0;
            info_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            remain_q   <= remain_d;
            id_q       <= id_d;
            info_rdy_q <= (state_d == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_id_q   <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_last_q <= issue_last;
                inflight_id_q   <= id_q;
            end
        end
    end

    // Store has no reset so its contents survive a responder reset; the read
    // samples the array before the same-edge write lands (read-first).
    always_ff @(posedge clk) begin
        if (wr_en_in) begin
            store_q[wr_addr_in] <= wr_data_in;
        end
        if (issue) begin
            rdata_q <= store_q[idx_q];
        end
    end

    resp_beat_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({inflight_last_q, inflight_id_q, rdata_q}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign rd_info_rdy_out   = info_rdy_q;
    assign rd_data_valid_out = fifo_valid;
    assign rd_data_last_out  = fifo_dout[FIFO_W-1];
    assign rd_data_id_out    = fifo_dout[FIFO_W-2 -: ID_W];
    assign rd_data_out       = fifo_dout[BEAT_W-1:0];

endmodule : ref_read_responder
`default_nettype wire

// File: tb/tb_ref_read_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ref_read_responder
// Brief   : Self-checking bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ref_read_responder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [255:0] d;
        logic [5:0]   id;
        logic         last;
    } beat_t;

    logic              clk;
    logic              rst;
    logic [5:0]        rd_id_in;
    logic [32:0]       rd_addr_in;
    logic [7:0]        rd_len_in;
    logic              rd_info_valid_in;
    logic              rd_info_rdy_out;
    logic [255:0]      rd_data_out;
    logic [5:0]        rd_data_id_out;
    logic              rd_data_last_out;
    logic              rd_data_valid_out;
    logic              rd_data_rdy_in;
    logic              wr_en_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic [255:0]      wr_data_in;

    logic [255:0] mem_m [DEPTH];
    beat_t        exp_q [$];
    int           checks;
    int           passed;
    int           beats_seen;
    int           cyc;
    int           rdy_mode;

    ref_read_responder #(.ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .rd_id_in          (rd_id_in),
        .rd_addr_in        (rd_addr_in),
        .rd_len_in         (rd_len_in),
        .rd_info_valid_in  (rd_info_valid_in),
        .rd_info_rdy_out   (rd_info_rdy_out),
        .rd_data_out       (rd_data_out),
        .rd_data_id_out    (rd_data_id_out),
        .rd_data_last_out  (rd_data_last_out),
        .rd_data_valid_out (rd_data_valid_out),
        .rd_data_rdy_in    (rd_data_rdy_in),
        .wr_en_in          (wr_en_in),
        .wr_addr_in        (wr_addr_in),
        .wr_data_in        (wr_data_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Consumer ready: 0 = always high, 1 = repeating 1,0,0,1, 2 = random.
    initial begin
        logic [3:0] pat;
        int         pidx;
        pat = 4'b1001;
        pidx = 0;
        rd_data_rdy_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       rd_data_rdy_in = pat[pidx % 4];
                2:       rd_data_rdy_in = 1'($urandom % 2);
                default: rd_data_rdy_in = 1'b1;
            endcase
            pidx = pidx + 1;
        end
    end

    // Data-port monitor: ordering, content and stall stability.
    initial begin
        logic         stall;
        logic [255:0] h_d;
        logic [5:0]   h_id;
        logic         h_last;
        beat_t        e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                checks = checks + 1;
                if (rd_data_valid_out !== 1'b1 || rd_data_out !== h_d ||
                    rd_data_id_out !== h_id || rd_data_last_out !== h_last)
                    $display("FAIL stall_stable got v=%b id=%0d last=%b d=%h required v=1 id=%0d last=%b d=%h",
                             rd_data_valid_out, rd_data_id_out, rd_data_last_out, rd_data_out,
                             h_id, h_last, h_d);
                else
                    passed = passed + 1;
            end
            stall = 1'b0;
            if (rd_data_valid_out === 1'b1) begin
                if (rd_data_rdy_in === 1'b1) begin
                    checks = checks + 1;
                    beats_seen = beats_seen + 1;
                    if (exp_q.size() == 0) begin
                        $display("FAIL beat_unexpected got id=%0d d=%h required no beat",
                                 rd_data_id_out, rd_data_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (rd_data_out !== e.d || rd_data_id_out !== e.id ||
                            rd_data_last_out !== e.last)
                            $display("FAIL beat got id=%0d last=%b d=%h required id=%0d last=%b d=%h",
                                     rd_data_id_out, rd_data_last_out, rd_data_out,
                                     e.id, e.last, e.d);
                        else
                            passed = passed + 1;
                    end
                end else begin
                    stall  = 1'b1;
                    h_d    = rd_data_out;
                    h_id   = rd_data_id_out;
                    h_last = rd_data_last_out;
                end
            end
        end
    end

    task automatic wr_word(input int w, input logic [255:0] d);
        wr_en_in   = 1'b1;
        wr_addr_in = ADDR_W'(w);
        wr_data_in = d;
        @(posedge clk);
        #1;
        wr_en_in = 1'b0;
        mem_m[w] = d;
    endtask

    task automatic send_req(input logic [5:0] id, input logic [32:0] addr,
                            input logic [7:0] len, output int acc);
        int    w;
        bit    ok;
        beat_t e;
        rd_id_in         = id;
        rd_addr_in       = addr;
        rd_len_in        = len;
        rd_info_valid_in = 1'b1;
        ok  = 1'b0;
        acc = -1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (rd_info_rdy_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks = checks + 1;
            $display("FAIL req_accept_timeout got rdy=%b required 1", rd_info_rdy_out);
            rd_info_valid_in = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            rd_info_valid_in = 1'b0;
            w = int'(addr[32:5] % DEPTH);
            for (int k = 0; k <= int'(len); k++) begin
                e.d    = mem_m[(w + k) % DEPTH];
                e.id   = id;
                e.last = (k == int'(len));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        @(posedge clk);
        #1;
        for (int n = 0; n < 3000; n++) begin
            if (exp_q.size() == 0 && rd_data_valid_out === 1'b0) break;
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks = checks + 1;
        if (exp_q.size() != 0 || rd_data_valid_out !== 1'b0)
            $display("FAIL drain got pending=%0d valid=%b required 0 0",
                     exp_q.size(), rd_data_valid_out);
        else
            passed = passed + 1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (rd_info_rdy_out !== 1'b0 || rd_data_valid_out !== 1'b0 ||
            rd_data_last_out !== 1'b0 || rd_data_id_out !== 6'd0 || rd_data_out !== 256'd0)
            $display("FAIL reset_outputs got rdy=%b v=%b last=%b id=%0d d=%h required all zero",
                     rd_info_rdy_out, rd_data_valid_out, rd_data_last_out,
                     rd_data_id_out, rd_data_out);
        else
            passed = passed + 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (rd_info_rdy_out !== 1'b0)
            $display("FAIL reset_release_rdy got %b required 0", rd_info_rdy_out);
        else
            passed = passed + 1;
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (rd_info_rdy_out !== 1'b1)
            $display("FAIL reset_first_edge_rdy got %b required 1", rd_info_rdy_out);
        else
            passed = passed + 1;
    endtask

    task automatic load_store();
        logic [255:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            if (i < 8) d = 256'(i * 32'h1111);
            wr_word(i, d);
        end
    endtask

    task automatic test_basic();
        int acc;
        logic [4:0] vpat;
        rdy_mode = 0;
        send_req(6'd5, 33'h40, 8'd3, acc);
        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (rd_data_valid_out !== 1'b0)
            $display("FAIL latency_early got valid=%b required 0", rd_data_valid_out);
        else
            passed = passed + 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vpat[i] = rd_data_valid_out;
        end
        checks = checks + 1;
        if (vpat !== 5'b01111)
            $display("FAIL basic_valid_train got %b required 01111", vpat);
        else
            passed = passed + 1;
        wait_drain();
    endtask

    task automatic test_backpressure();
        int acc;
        int base;
        rdy_mode = 1;
        base = beats_seen;
        send_req(6'd5, 33'h40, 8'd3, acc);
        wait_drain();
        checks = checks + 1;
        if (beats_seen - base != 4)
            $display("FAIL bp_beat_count got %0d required 4", beats_seen - base);
        else
            passed = passed + 1;
        rdy_mode = 0;
    endtask

    task automatic test_wrap();
        int acc;
        int base;
        base = beats_seen;
        send_req(6'd9, 33'(1022) << 5, 8'd3, acc);
        wait_drain();
        checks = checks + 1;
        if (beats_seen - base != 4)
            $display("FAIL wrap_beat_count got %0d required 4", beats_seen - base);
        else
            passed = passed + 1;
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        logic [4:0] vpat;
        rdy_mode = 0;
        send_req(6'd1, 33'h60, 8'd0, acc1);
        send_req(6'd2, 33'h80, 8'd1, acc2);
        checks = checks + 1;
        if (acc2 - acc1 != 2)
            $display("FAIL b2b_accept_gap got %0d required 2", acc2 - acc1);
        else
            passed = passed + 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vpat[i] = rd_data_valid_out;
        end
        checks = checks + 1;
        if (vpat !== 5'b01101)
            $display("FAIL b2b_valid_train got %b required 01101", vpat);
        else
            passed = passed + 1;
        wait_drain();
    endtask

    task automatic test_read_first();
        int acc;
        logic [255:0] nd;
        for (int k = 0; k < 8; k++) nd[k*32 +: 32] = $urandom;
        send_req(6'd3, 33'(7) << 5, 8'd0, acc);
        wr_word(7, nd);
        wait_drain();
        send_req(6'd4, 33'(7) << 5, 8'd0, acc);
        wait_drain();
    endtask

    task automatic test_reset_midburst();
        int acc;
        int base;
        bit ok;
        rdy_mode = 0;
        base = beats_seen;
        send_req(6'd6, 33'h0, 8'd7, acc);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #2;
            if (beats_seen - base >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checks = checks + 1;
        if (!ok)
            $display("FAIL midrst_two_beats got %0d required 2", beats_seen - base);
        else
            passed = passed + 1;
        #1;
        rst = 1'b0;
        #1;
        checks = checks + 1;
        if (rd_data_valid_out !== 1'b0 || rd_info_rdy_out !== 1'b0 || rd_data_out !== 256'd0)
            $display("FAIL midrst_async got v=%b rdy=%b d=%h required 0 0 0",
                     rd_data_valid_out, rd_info_rdy_out, rd_data_out);
        else
            passed = passed + 1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (rd_info_rdy_out !== 1'b1 || rd_data_valid_out !== 1'b0)
            $display("FAIL midrst_release got rdy=%b v=%b required 1 0",
                     rd_info_rdy_out, rd_data_valid_out);
        else
            passed = passed + 1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks = checks + 1;
        if (rd_data_valid_out !== 1'b0)
            $display("FAIL midrst_flushed got v=%b required 0", rd_data_valid_out);
        else
            passed = passed + 1;
        send_req(6'd6, 33'h0, 8'd7, acc);
        wait_drain();
    endtask

    task automatic test_random();
        int acc;
        logic [255:0] d;
        rdy_mode = 2;
        for (int it = 0; it < 12; it++) begin
            if ($urandom % 2 == 1) begin
                for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
                wr_word(int'($urandom % DEPTH), d);
            end
            for (int r = 0; r < int'($urandom_range(1, 3)); r++)
                send_req(6'($urandom), 33'({$urandom, $urandom}), 8'($urandom_range(0, 15)), acc);
            wait_drain();
        end
        send_req(6'd63, 33'($urandom_range(0, DEPTH - 1)) << 5, 8'd255, acc);
        wait_drain();
        rdy_mode = 0;
    endtask

    initial begin
        checks           = 0;
        passed           = 0;
        beats_seen       = 0;
        rdy_mode         = 0;
        rst              = 1'b0;
        rd_id_in         = '0;
        rd_addr_in       = '0;
        rd_len_in        = '0;
        rd_info_valid_in = 1'b0;
        wr_en_in         = 1'b0;
        wr_addr_in       = '0;
        wr_data_in       = '0;
        @(posedge clk);
        #1;
        test_reset();
        load_store();
        test_basic();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_read_first();
        test_reset_midburst();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_ref_read_responder
`default_nettype wire
